// File: rtl/skid_buffer_reg.sv
// Two-entry skid buffer with fully registered in_ready, out and out_valid.
// Optional downstream stall-cycle counter enabled by defining SKID_STALL_CNT_EN.
module skid_buffer_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SKID_STALL_CNT_EN
  ,output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             out_valid_r;
  logic             out_valid_s;
  logic             in_ready_r;
  logic             in_ready_s;
  logic             up_xfer_s;
  logic             down_xfer_s;

  assign up_xfer_s   = in_valid && in_ready_r;
  assign down_xfer_s = out_valid_r && out_ready;

  // Next-state, next-payload and next-ready computation.
  always_comb begin
    state_s = state_r;
    out_s   = out_r;
    skid_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (up_xfer_s) begin
          out_s   = in;
          state_s = ST_BUSY;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (up_xfer_s && down_xfer_s) begin
          out_s   = in;
          state_s = ST_BUSY;
        end else if (up_xfer_s) begin
          skid_s  = in;
          state_s = ST_FULL;
        end else if (down_xfer_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so any upstream offer is ignored
        if (out_ready) begin
          out_s   = skid_r;
          state_s = ST_BUSY;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
    out_valid_s = (state_s != ST_EMPTY);
    in_ready_s  = (state_s != ST_FULL);
  end

  // State and output registers; reset clears both words without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_EMPTY;
      out_r       <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_r       <= out_s;
      skid_r      <= skid_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

`ifdef SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of edges where downstream holds off a valid word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_skid_buffer_reg.sv
// Self-checking bench for skid_buffer_reg: queue-based reference model plus
// transfer scoreboard; stall counter checks run when SKID_STALL_CNT_EN is defined.
module tb_skid_buffer_reg;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
`ifdef SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int failures;
  int accepted;

  // reference model: the buffer is just an ordered list of at most two words
  logic [7:0]  mq[$];
  logic [7:0]  sb[$];
  logic [7:0]  m_out;
  logic        m_in_ready;
  logic [15:0] m_stall;

  skid_buffer_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SKID_STALL_CNT_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_out      = 8'h00;
    m_in_ready = 1'b0;
    m_stall    = 16'd0;
  endtask

  // one clock cycle: scoreboard, model update, then compare after the edge
  task automatic tick();
    logic [7:0] exp_w;
    logic [7:0] pre_out;
    logic [7:0] tmp;
    bit hold;
    bit up;
    bit down;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got word %h, expected no word", out);
      end else begin
        exp_w = sb.pop_front();
        if (out !== exp_w) begin
          failures++;
          $display("FAIL sb_order: got %h, expected %h", out, exp_w);
        end
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      sb.push_back(in);
      accepted++;
    end
    hold    = (out_valid === 1'b1 && out_ready === 1'b0);
    pre_out = out;
    up      = in_valid && m_in_ready;
    down    = (mq.size() > 0) && out_ready;
    if (mq.size() > 0 && !out_ready && m_stall != 16'hFFFF) m_stall++;
    if (down) tmp = mq.pop_front();
    if (up) mq.push_back(in);
    if (mq.size() > 0) m_out = mq[0];
    m_in_ready = (mq.size() < 2);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== (mq.size() > 0)) begin
      failures++;
      $display("FAIL model_out_valid: got %b, expected %b", out_valid, (mq.size() > 0));
    end
    checks++;
    if (in_ready !== m_in_ready) begin
      failures++;
      $display("FAIL model_in_ready: got %b, expected %b", in_ready, m_in_ready);
    end
    checks++;
    if (out !== m_out) begin
      failures++;
      $display("FAIL model_out: got %h, expected %h", out, m_out);
    end
`ifdef SKID_STALL_CNT_EN
    checks++;
    if (stall_cnt !== m_stall) begin
      failures++;
      $display("FAIL model_stall_cnt: got %h, expected %h", stall_cnt, m_stall);
    end
`endif
    if (hold) begin
      checks++;
      if (out !== pre_out || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable: got out=%h valid=%b, expected out=%h valid=1",
                 out, out_valid, pre_out);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in        = 8'h77;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got out=%h valid=%b ready=%b, expected 00 0 0",
               out, out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: got %b, expected 0", in_ready);
    end
    // in_valid is high, but nothing may be taken before in_ready rises
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_edge: got ready=%b valid=%b, expected 1 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    in        = 8'hA5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 8'hA5 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_word: got out=%h valid=%b ready=%b, expected a5 1 1",
               out, out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in       = i[7:0];
      in_valid = 1'b1;
      tick();
      checks++;
      if (out !== i[7:0] || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back: got out=%h valid=%b ready=%b, expected %h 1 1",
                 out, out_valid, in_ready, i[7:0]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid();
    in        = 8'h11;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in = 8'h22;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out !== 8'h11 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL skid_full: got ready=%b out=%h valid=%b, expected 0 11 1",
               in_ready, out, out_valid);
    end
    in = 8'h33;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out !== 8'h11) begin
      failures++;
      $display("FAIL skid_ignore: got ready=%b out=%h, expected 0 11", in_ready, out);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out !== 8'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL skid_drain1: got out=%h valid=%b ready=%b, expected 22 1 1",
               out, out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out !== 8'h22) begin
      failures++;
      $display("FAIL skid_drain2: got valid=%b out=%h, expected 0 22", out_valid, out);
    end
  endtask

  task automatic test_random();
    int start;
    int cyc;
    start = accepted;
    cyc   = 0;
    while ((accepted - start) < 1000 && cyc < 20000) begin
      in        = 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    checks++;
    if ((accepted - start) < 1000) begin
      failures++;
      $display("FAIL random_budget: got %0d words, expected 1000", accepted - start);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((sb.size() > 0 || out_valid === 1'b1) && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_drain: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    in        = 8'h5A;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in = 8'hC3;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_setup: got ready=%b valid=%b, expected 0 1", in_ready, out_valid);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: got valid=%b ready=%b out=%h, expected 0 0 00",
               out_valid, in_ready, out);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_release: got ready=%b valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

`ifdef SKID_STALL_CNT_EN
  task automatic test_stall_saturate();
    in        = 8'h99;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_saturate: got %h, expected ffff", stall_cnt);
    end
    repeat (5) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_no_wrap: got %h, expected ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    accepted = 0;
    rst       = 1'b0;
    in        = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_random();
    test_async_reset();
`ifdef SKID_STALL_CNT_EN
    test_stall_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
